// File: rtl/pwm16_pkg.sv
// Shared types and defaults for the pwm16 DAC output stage.
package pwm16_pkg;

  localparam int DW_DEF     = 16;
  localparam int UCNT_W_DEF = 8;

  typedef logic [DW_DEF-1:0] duty_t;

  // Counter direction, only meaningful for the centre-aligned counter.
  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm16_if.sv
// Sample stream (valid/ready) carrying quantized duty words into pwm16_out.
interface pwm16_if #(
  parameter int DW = pwm16_pkg::DW_DEF
) ();

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/pwm16_counter.sv
// PWM period counter. Emits the next counter value and a load strobe
// marking the last cycle of a period (or the first enabled cycle).
// PWM16_OUT_CENTER_ALIGN_EN selects an up/down counter with both endpoints
// held one cycle; otherwise a plain wrapping up-counter is built.
module pwm16_counter
  import pwm16_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [DW-1:0] cnt_nxt,
  output logic          load
);

  localparam logic [DW-1:0] CNT_MAX = '1;

  logic          run_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          first_cyc;

  // First enabled cycle after idle or reset always starts a fresh period.
  assign first_cyc = en && !run_q;

`ifdef PWM16_OUT_CENTER_ALIGN_EN
  cnt_dir_e dir_q, dir_d;

  // Up 0..max, hold max, down to 0, hold 0; load on the bottom hold.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no
    // branch can leave a value unassigned and infer a latch.
    cnt_d = cnt_q;
    dir_d = dir_q;
    load  = 1'b0;
    if (!en) begin
      cnt_d = '0;
      dir_d = CNT_UP;
    end else if (first_cyc || (dir_q == CNT_DOWN && cnt_q == '0)) begin
      load  = 1'b1;
      cnt_d = '0;
      dir_d = CNT_UP;
    end else if (dir_q == CNT_UP) begin
      if (cnt_q == CNT_MAX) dir_d = CNT_DOWN;
      else                  cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Direction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= CNT_UP;
    else        dir_q <= dir_d;
  end
`else
  // Wrapping up-counter; load on the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    load  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (first_cyc || cnt_q == CNT_MAX) begin
      load  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
`endif

  // Counter and run-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // independent of statement order.
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= en;
    end
  end

  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/pwm16_out.sv
// PWM DAC output stage: double-buffered duty (pending -> active swapped only
// at a period boundary), registered compare, underrun reporting.
// Build option: PWM16_OUT_CENTER_ALIGN_EN (centre-aligned counter, consumed
// inside pwm16_counter).
module pwm16_out
  import pwm16_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int UCNT_W = UCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  pwm16_if.slave            s,
  output logic              pwm_out,
  output logic              period_start,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt,
  input  logic              underrun_clr
);

  localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

  logic [DW-1:0]     cnt_nxt;
  logic              load;

  logic [DW-1:0]     pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [DW-1:0]     active_q, active_d;
  logic              pwm_q, pwm_d;
  logic              period_start_q, period_start_d;
  logic              underrun_q, underrun_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;

  logic              accept;
  logic              swap;
  logic              miss;

  pwm16_counter #(.DW(DW)) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cnt_nxt (cnt_nxt),
    .load    (load)
  );

  // Ready depends only on buffer state, never on s_valid.
  assign s.s_ready = ~pend_full_q;

  // Handshake, buffer swap, compare and underrun bookkeeping.
  always_comb begin
    accept = s.s_valid && !pend_full_q;
    swap   = load && pend_full_q;
    miss   = load && !pend_full_q;

    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;

    // Accept and swap are exclusive: accept needs the buffer empty.
    if (swap) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_d      = s.s_data;
      pend_full_d = 1'b1;
    end

    // Compare against next-cycle count and post-load duty so the output
    // stays aligned with the counter and a new duty applies from cnt==0.
    pwm_d = en && (cnt_nxt < active_d);

    period_start_d = load;
    underrun_d     = miss;

    ucnt_d = ucnt_q;
    if (underrun_clr)                  ucnt_d = '0;
    else if (miss && ucnt_q != UCNT_MAX) ucnt_d = ucnt_q + 1'b1;
  end

  // State registers; everything returns to idle on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q         <= '0;
      pend_full_q    <= 1'b0;
      active_q       <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
      ucnt_q         <= '0;
    end else begin
      pend_q         <= pend_d;
      pend_full_q    <= pend_full_d;
      active_q       <= active_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
      ucnt_q         <= ucnt_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

endmodule
